tcm_dport_arb: RTL and testbench
================================

TCM_DPORT_ARB -- requirements
Module: tcm_dport_arb

Interface
REQ-001 Parameter DEPTH, default 4: max outstanding accepted requests awaiting response (power of two, >=2).
REQ-002 Parameter TAG_W, default 11: request/response tag width.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 p0_addr_i/p0_data_wr_i  in  32/32  port 0 (CPU data) address, write data.
REQ-006 p0_rd_i/p0_wr_i/p0_req_tag_i  in  1/4/TAG_W  port 0 read strobe, byte write enables, tag.
REQ-007 p0_cacheable_i/p0_invalidate_i/p0_writeback_i/p0_flush_i  in  1 each  port 0 cache-maintenance sideband.
REQ-008 p1_addr_i/p1_data_wr_i/p1_rd_i/p1_wr_i/p1_req_tag_i  in  32/32/1/4/TAG_W  port 1 (loader/debug master) request.
REQ-009 pN_accept_o/pN_ack_o/pN_error_o  out  1 each  per-port accept, response valid, response error (N=0,1).
REQ-010 pN_data_rd_o/pN_resp_tag_o  out  32/TAG_W  per-port read data, response tag.
REQ-011 m_addr_o/m_data_wr_o/m_rd_o/m_wr_o/m_req_tag_o  out  32/32/1/4/TAG_W  merged request to TCM data port.
REQ-012 m_cacheable_o/m_invalidate_o/m_writeback_o/m_flush_o  out  1 each  sideband to TCM.
REQ-013 m_accept_i/m_ack_i/m_error_i  in  1 each  TCM accept, response valid, error.
REQ-014 m_data_rd_i/m_resp_tag_i  in  32/TAG_W  TCM read data, response tag.
REQ-015 busy_o  out  1  outstanding count non-zero.
REQ-016 proto_err_o  out  1  sticky: m_ack_i seen with no outstanding request.

Function
REQ-017 A port requests when rd_i=1 or wr_i!=0; request path to m_* is combinational (zero added latency).
REQ-018 Arbitration is round-robin: priority register prio selects favoured port; prio flips to the non-winner on every accepted transfer.
REQ-019 Lock: if granted port's request is not accepted this cycle, grant stays on that port next cycle regardless of prio; requesters hold request stable until accept.
REQ-020 m_rd_o/m_wr_o driven only for the granted port, forced 0 when FIFO full or no request; non-granted port accept_o=0.
REQ-021 pN_accept_o = granted(N) & m_accept_i & !full.
REQ-022 Sideband (cacheable/invalidate/writeback/flush) passes from port 0 only; m_cacheable_o=0 while port 1 granted.
REQ-023 Source FIFO of DEPTH entries stores winner ID (1 bit) per accepted request; push on accept, pop on m_ack_i.
REQ-024 Responses are in-order: m_ack_i/m_error_i/m_data_rd_i/m_resp_tag_i routed combinationally to port at FIFO head; other port ack_o=0.
REQ-025 Full (count==DEPTH) blocks new requests even if pop occurs same cycle; simultaneous push+pop below full leaves count unchanged.
REQ-026 Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-027 m_ack_i with count==0: no pop, no port ack, proto_err_o set until reset.
REQ-028 pN_data_rd_o/pN_resp_tag_o equal m_* inputs unqualified; consumers qualify with ack_o.

Reset
REQ-029 While rst=0 on clk edge: count=0, pointers=0, prio=port 0, lock cleared, proto_err_o=0.
REQ-030 During and after reset all accept_o, ack_o, m_rd_o, m_wr_o, busy_o are 0; responses to pre-reset requests are not routed.

Structure
REQ-031 Shared package holds port ID type, default DEPTH/TAG_W constants, request-valid helper.
REQ-032 One sub-module, tcm_arb_src_fifo (DEPTH x 1-bit sync FIFO with count/full/empty); arbitration and routing stay in top.

Verification
REQ-033 Port 0 read 0x80000000, tag 5, TCM accepts, acks next cycle -> p0_accept_o=1, one cycle later p0_ack_o=1, p0_resp_tag_o=5, p1_ack_o=0.
REQ-034 Both ports request continuously, m_accept_i=1 -> grants alternate p0,p1,p0,p1; each port 50% of accepts over 20 cycles.
REQ-035 p1 granted, m_accept_i=0 for 3 cycles while p0 asserts -> grant stays p1; p1 accepted on cycle 4; p0 next.
REQ-036 Four accepts with no ack (DEPTH=4) -> fifth request sees accept_o=0, m_rd_o=0; single ack -> next cycle accept resumes.
REQ-037 Interleaved p0,p1,p0 accepted, acks in order -> ack_o on p0,p1,p0 respectively with matching tags and data.
REQ-038 m_ack_i with idle FIFO -> proto_err_o=1 and stays; rst=0 one cycle -> proto_err_o=0, busy_o=0.

Source files
------------

// File: rtl/tcm_dport_arb_pkg.sv
// Shared types and helpers for the TCM data-port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tcm_dport_arb_pkg;

  // Identifies which upstream port owns a request or response.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_TAG_W = 11;

  // A port presents a request when it reads or writes at least one byte.
  function automatic logic req_valid(input logic rd, input logic [3:0] wr);
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/tcm_arb_src_fifo.sv
// DEPTH x 1-bit source-ID FIFO recording which port owns each outstanding request.
// Latency: head visible combinationally; push/pop take effect on the next clk edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module tcm_arb_src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_dat,
  input  logic                   pop,
  output logic                   head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tcm_dport_arb.sv
// Two-port round-robin arbiter merging CPU (port 0) and loader (port 1) onto one TCM data port.
// Latency: request and response paths are combinational (zero added cycles).
// Backpressure: m_accept_i and a full source FIFO stall the granted port; grant is held until accepted.
module tcm_dport_arb
  import tcm_dport_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  // port 0: CPU data
  input  logic [31:0]      p0_addr_i,
  input  logic [31:0]      p0_data_wr_i,
  input  logic             p0_rd_i,
  input  logic [3:0]       p0_wr_i,
  input  logic [TAG_W-1:0] p0_req_tag_i,
  input  logic             p0_cacheable_i,
  input  logic             p0_invalidate_i,
  input  logic             p0_writeback_i,
  input  logic             p0_flush_i,
  output logic             p0_accept_o,
  output logic             p0_ack_o,
  output logic             p0_error_o,
  output logic [31:0]      p0_data_rd_o,
  output logic [TAG_W-1:0] p0_resp_tag_o,
  // port 1: loader / debug master
  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_data_wr_i,
  input  logic             p1_rd_i,
  input  logic [3:0]       p1_wr_i,
  input  logic [TAG_W-1:0] p1_req_tag_i,
  output logic             p1_accept_o,
  output logic             p1_ack_o,
  output logic             p1_error_o,
  output logic [31:0]      p1_data_rd_o,
  output logic [TAG_W-1:0] p1_resp_tag_o,
  // merged TCM data port
  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_data_wr_o,
  output logic             m_rd_o,
  output logic [3:0]       m_wr_o,
  output logic [TAG_W-1:0] m_req_tag_o,
  output logic             m_cacheable_o,
  output logic             m_invalidate_o,
  output logic             m_writeback_o,
  output logic             m_flush_o,
  input  logic             m_accept_i,
  input  logic             m_ack_i,
  input  logic             m_error_i,
  input  logic [31:0]      m_data_rd_i,
  input  logic [TAG_W-1:0] m_resp_tag_i,
  // status
  output logic             busy_o,
  output logic             proto_err_o
);

  logic                   p0_req;
  logic                   p1_req;
  port_id_t               prio;
  port_id_t               lock_port;
  logic                   lock_vld;
  port_id_t               gnt_port;
  logic                   gnt_vld;
  logic                   issue;
  logic                   acc;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   head_raw;
  port_id_t               head_port;
  logic                   ack_vld;
  logic                   proto_err;
  logic [$clog2(DEPTH):0] fifo_count;

  assign p0_req = req_valid(p0_rd_i, p0_wr_i);
  assign p1_req = req_valid(p1_rd_i, p1_wr_i);

  // Grant select: a stalled grant is held, otherwise prio breaks ties between requesters.
  always_comb begin
    gnt_port = prio;
    gnt_vld  = 1'b0;
    if (lock_vld && ((lock_port == PORT0) ? p0_req : p1_req)) begin
      gnt_port = lock_port;
      gnt_vld  = 1'b1;
    end else if (p0_req && p1_req) begin
      gnt_port = prio;
      gnt_vld  = 1'b1;
    end else if (p0_req) begin
      gnt_port = PORT0;
      gnt_vld  = 1'b1;
    end else if (p1_req) begin
      gnt_port = PORT1;
      gnt_vld  = 1'b1;
    end
  end

  // Reset gates issue so nothing leaks to the TCM before the state registers are cleared.
  assign issue = rst & gnt_vld & ~fifo_full;
  assign acc   = issue & m_accept_i;

  assign p0_accept_o = acc & (gnt_port == PORT0);
  assign p1_accept_o = acc & (gnt_port == PORT1);

  // Request mux: payload follows the grant; strobes only while issuing; sideband only from port 0.
  always_comb begin
    m_addr_o       = (gnt_port == PORT1) ? p1_addr_i    : p0_addr_i;
    m_data_wr_o    = (gnt_port == PORT1) ? p1_data_wr_i : p0_data_wr_i;
    m_req_tag_o    = (gnt_port == PORT1) ? p1_req_tag_i : p0_req_tag_i;
    m_rd_o         = issue & ((gnt_port == PORT1) ? p1_rd_i : p0_rd_i);
    m_wr_o         = issue ? ((gnt_port == PORT1) ? p1_wr_i : p0_wr_i) : 4'h0;
    m_cacheable_o  = (gnt_port == PORT0) & p0_cacheable_i;
    m_invalidate_o = (gnt_port == PORT0) & p0_invalidate_i;
    m_writeback_o  = (gnt_port == PORT0) & p0_writeback_i;
    m_flush_o      = (gnt_port == PORT0) & p0_flush_i;
  end

  // Arbitration state: prio moves to the loser on accept; an unaccepted grant is locked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio      <= PORT0;
      lock_vld  <= 1'b0;
      lock_port <= PORT0;
      proto_err <= 1'b0;
    end else begin
      if (acc) begin
        prio     <= (gnt_port == PORT0) ? PORT1 : PORT0;
        lock_vld <= 1'b0;
      end else begin
        lock_vld  <= gnt_vld;
        lock_port <= gnt_port;
      end
      if (m_ack_i && fifo_empty) begin
        proto_err <= 1'b1;
      end
    end
  end

  tcm_arb_src_fifo #(
    .DEPTH (DEPTH)
  ) u_src_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (acc),
    .push_dat (gnt_port),
    .pop      (ack_vld),
    .head_dat (head_raw),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_port = port_id_t'(head_raw);
  assign ack_vld   = rst & m_ack_i & ~fifo_empty;

  assign p0_ack_o      = ack_vld & (head_port == PORT0);
  assign p1_ack_o      = ack_vld & (head_port == PORT1);
  assign p0_error_o    = p0_ack_o & m_error_i;
  assign p1_error_o    = p1_ack_o & m_error_i;
  assign p0_data_rd_o  = m_data_rd_i;
  assign p1_data_rd_o  = m_data_rd_i;
  assign p0_resp_tag_o = m_resp_tag_i;
  assign p1_resp_tag_o = m_resp_tag_i;

  assign busy_o      = rst & (fifo_count != '0);
  assign proto_err_o = proto_err;

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Randomized scoreboard bench for tcm_dport_arb against a transaction-level model.
// Latency: model expects same-cycle accept and same-cycle response routing.
// Backpressure: bench holds each request until its accept, and randomizes m_accept_i.
module tb_tcm_dport_arb;
  localparam int DEPTH = 4;
  localparam int TAG_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] p0_addr_i = '0, p0_data_wr_i = '0, p1_addr_i = '0, p1_data_wr_i = '0;
  logic        p0_rd_i = 1'b0, p1_rd_i = 1'b0;
  logic [3:0]  p0_wr_i = '0, p1_wr_i = '0;
  logic [TAG_W-1:0] p0_req_tag_i = '0, p1_req_tag_i = '0;
  logic p0_cacheable_i = 1'b0, p0_invalidate_i = 1'b0, p0_writeback_i = 1'b0, p0_flush_i = 1'b0;
  logic p0_accept_o, p0_ack_o, p0_error_o, p1_accept_o, p1_ack_o, p1_error_o;
  logic [31:0] p0_data_rd_o, p1_data_rd_o;
  logic [TAG_W-1:0] p0_resp_tag_o, p1_resp_tag_o;
  logic [31:0] m_addr_o, m_data_wr_o;
  logic        m_rd_o;
  logic [3:0]  m_wr_o;
  logic [TAG_W-1:0] m_req_tag_o;
  logic m_cacheable_o, m_invalidate_o, m_writeback_o, m_flush_o;
  logic m_accept_i = 1'b0, m_ack_i = 1'b0, m_error_i = 1'b0;
  logic [31:0] m_data_rd_i = '0;
  logic [TAG_W-1:0] m_resp_tag_i = '0;
  logic busy_o, proto_err_o;

  always #5 clk = ~clk;

  tcm_dport_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .p0_addr_i(p0_addr_i), .p0_data_wr_i(p0_data_wr_i), .p0_rd_i(p0_rd_i), .p0_wr_i(p0_wr_i),
    .p0_req_tag_i(p0_req_tag_i), .p0_cacheable_i(p0_cacheable_i), .p0_invalidate_i(p0_invalidate_i),
    .p0_writeback_i(p0_writeback_i), .p0_flush_i(p0_flush_i),
    .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o), .p0_error_o(p0_error_o),
    .p0_data_rd_o(p0_data_rd_o), .p0_resp_tag_o(p0_resp_tag_o),
    .p1_addr_i(p1_addr_i), .p1_data_wr_i(p1_data_wr_i), .p1_rd_i(p1_rd_i), .p1_wr_i(p1_wr_i),
    .p1_req_tag_i(p1_req_tag_i),
    .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o), .p1_error_o(p1_error_o),
    .p1_data_rd_o(p1_data_rd_o), .p1_resp_tag_o(p1_resp_tag_o),
    .m_addr_o(m_addr_o), .m_data_wr_o(m_data_wr_o), .m_rd_o(m_rd_o), .m_wr_o(m_wr_o),
    .m_req_tag_o(m_req_tag_o), .m_cacheable_o(m_cacheable_o), .m_invalidate_o(m_invalidate_o),
    .m_writeback_o(m_writeback_o), .m_flush_o(m_flush_o),
    .m_accept_i(m_accept_i), .m_ack_i(m_ack_i), .m_error_i(m_error_i),
    .m_data_rd_i(m_data_rd_i), .m_resp_tag_i(m_resp_tag_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  typedef struct { int port; logic [TAG_W-1:0] tag; } pend_t;
  typedef struct { int port; logic [TAG_W-1:0] tag; logic [31:0] data; logic err; } exp_t;

  int    checks = 0, failures = 0;
  pend_t pend_q[$];   // accepted by TCM, response not yet returned (in order)
  exp_t  exp_q[$];    // responses issued, awaiting routing to a port
  int    fav = 0, held = -1, seq = 0;
  bit    proto_exp = 1'b0, ack_en = 1'b0, dut_acc0, dut_acc1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic new_req(input int p);
    logic [TAG_W-1:0] t;
    logic rd;
    logic [3:0] wr;
    seq++;
    t = TAG_W'(seq);
    t[TAG_W-1] = (p == 1);
    rd = 1'($urandom_range(0, 1));
    wr = rd ? 4'h0 : 4'($urandom_range(1, 15));
    if (p == 0) begin
      p0_rd_i = rd; p0_wr_i = wr; p0_addr_i = $urandom; p0_data_wr_i = $urandom; p0_req_tag_i = t;
      p0_cacheable_i = 1'($urandom_range(0, 1)); p0_invalidate_i = 1'($urandom_range(0, 1));
      p0_writeback_i = 1'($urandom_range(0, 1)); p0_flush_i = 1'($urandom_range(0, 1));
    end else begin
      p1_rd_i = rd; p1_wr_i = wr; p1_addr_i = $urandom; p1_data_wr_i = $urandom; p1_req_tag_i = t;
    end
  endtask

  task automatic clear_req(input int p);
    if (p == 0) begin p0_rd_i = 1'b0; p0_wr_i = 4'h0; end
    else begin p1_rd_i = 1'b0; p1_wr_i = 4'h0; end
  endtask

  // One clock of stimulus: drive TCM response, compare the request side with the model,
  // post the expected response to the scoreboard, then advance the model across the edge.
  task automatic step();
    int win;
    bit full, acc, r0, r1, wrd;
    logic [3:0] wwr;
    logic [31:0] waddr;
    logic [TAG_W-1:0] wtag;
    exp_t e;
    m_ack_i      = ack_en;
    m_data_rd_i  = $urandom;
    m_error_i    = 1'($urandom_range(0, 1));
    m_resp_tag_i = TAG_W'($urandom);
    if (ack_en && pend_q.size() > 0) m_resp_tag_i = pend_q[0].tag;
    #1;
    r0 = p0_rd_i || (p0_wr_i != 4'h0);
    r1 = p1_rd_i || (p1_wr_i != 4'h0);
    win = -1;
    if (held == 0 && r0) win = 0;
    else if (held == 1 && r1) win = 1;
    else if (r0 && r1) win = fav;
    else if (r0) win = 0;
    else if (r1) win = 1;
    wrd   = (win == 1) ? p1_rd_i : p0_rd_i;
    wwr   = (win == 1) ? p1_wr_i : p0_wr_i;
    waddr = (win == 1) ? p1_addr_i : p0_addr_i;
    wtag  = (win == 1) ? p1_req_tag_i : p0_req_tag_i;
    full  = (pend_q.size() >= DEPTH);
    acc   = rst && win >= 0 && m_accept_i && !full;
    dut_acc0 = p0_accept_o;
    dut_acc1 = p1_accept_o;
    chk("p0_accept", p0_accept_o, acc && win == 0);
    chk("p1_accept", p1_accept_o, acc && win == 1);
    chk("m_rd", m_rd_o, rst && win >= 0 && !full && wrd);
    chk("m_wr", m_wr_o, (rst && win >= 0 && !full) ? wwr : 4'h0);
    if (acc) begin
      chk("m_req_tag", m_req_tag_o, wtag);
      chk("m_addr", m_addr_o, waddr);
    end
    if (rst && win == 1) chk("m_cacheable_p1", m_cacheable_o, 1'b0);
    if (rst && win == 0) chk("m_cacheable_p0", m_cacheable_o, p0_cacheable_i);
    chk("busy", busy_o, rst && pend_q.size() != 0);
    chk("proto_err", proto_err_o, proto_exp);
    if (rst && ack_en && pend_q.size() > 0) begin
      e.port = pend_q[0].port; e.tag = pend_q[0].tag; e.data = m_data_rd_i; e.err = m_error_i;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!rst) begin
      pend_q.delete();
      held = -1; fav = 0; proto_exp = 1'b0;
    end else begin
      if (ack_en) begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        else proto_exp = 1'b1;
      end
      if (acc) begin
        pend_q.push_back('{port: win, tag: wtag});
        fav = 1 - win; held = -1;
      end else begin
        held = win;
      end
    end
    #1;
    m_ack_i = 1'b0;
  endtask

  task automatic drain();
    clear_req(0); clear_req(1);
    for (int i = 0; i < 20 && pend_q.size() > 0; i++) begin
      ack_en = 1'b1;
      step();
    end
    ack_en = 1'b0;
  endtask

  // Response monitor: every routed ack must match the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (p0_ack_o || p1_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_ack: p0_ack=%0d p1_ack=%0d expected none", p0_ack_o, p1_ack_o);
      end else begin
        e = exp_q.pop_front();
        chk("ack_p0", p0_ack_o, e.port == 0);
        chk("ack_p1", p1_ack_o, e.port == 1);
        chk("resp_tag", (e.port == 1) ? p1_resp_tag_o : p0_resp_tag_o, e.tag);
        chk("resp_data", (e.port == 1) ? p1_data_rd_o : p0_data_rd_o, e.data);
        chk("resp_err", (e.port == 1) ? p1_error_o : p0_error_o, e.err);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL missing_ack: no port ack, expected ack on port %0d tag 0x%0h", e.port, e.tag);
    end
  end

  initial begin
    int cnt0, cnt1;
    // Reset with requests and a stray ack present: nothing may be accepted or routed.
    @(posedge clk); #1;
    new_req(0); new_req(1); m_accept_i = 1'b1; ack_en = 1'b1;
    step(); step();
    ack_en = 1'b0; clear_req(0); clear_req(1);
    rst = 1'b1;
    step();

    // Single port-0 read, acked one cycle later.
    p0_rd_i = 1'b1; p0_wr_i = 4'h0; p0_addr_i = 32'h8000_0000; p0_req_tag_i = TAG_W'(5);
    step();
    chk("single_accept", dut_acc0, 1'b1);
    clear_req(0);
    ack_en = 1'b1; step(); ack_en = 1'b0;

    // Both ports saturating: alternate grants, equal share over 20 cycles.
    cnt0 = 0; cnt1 = 0;
    new_req(0); new_req(1);
    for (int i = 0; i < 20; i++) begin
      ack_en = (pend_q.size() > 0);
      step();
      if (dut_acc0) begin cnt0++; new_req(0); end
      if (dut_acc1) begin cnt1++; new_req(1); end
    end
    chk("rr_share_p0", cnt0, 10);
    chk("rr_share_p1", cnt1, 10);
    drain();

    // Lock: p1 granted and stalled three cycles while p0 waits.
    m_accept_i = 1'b0;
    new_req(1); step();
    new_req(0); step(); step();
    m_accept_i = 1'b1; step();
    chk("lock_p1_accept", dut_acc1, 1'b1);
    chk("lock_p0_wait", dut_acc0, 1'b0);
    clear_req(1); step();
    chk("lock_p0_next", dut_acc0, 1'b1);
    drain();

    // Full: four outstanding block the fifth, even on the cycle the ack pops.
    for (int i = 0; i < DEPTH; i++) begin new_req(0); step(); end
    new_req(0); step();
    chk("full_block", dut_acc0, 1'b0);
    ack_en = 1'b1; step(); ack_en = 1'b0;
    chk("full_pop_block", dut_acc0, 1'b0);
    step();
    chk("full_resume", dut_acc0, 1'b1);
    drain();

    // Randomized traffic.
    clear_req(0); clear_req(1);
    for (int i = 0; i < 800; i++) begin
      if (!(p0_rd_i || p0_wr_i != 4'h0) && $urandom_range(0, 1)) new_req(0);
      if (!(p1_rd_i || p1_wr_i != 4'h0) && $urandom_range(0, 1)) new_req(1);
      m_accept_i = ($urandom_range(0, 3) != 0);
      ack_en = (pend_q.size() > 0) && ($urandom_range(0, 2) == 0);
      step();
      if (dut_acc0) clear_req(0);
      if (dut_acc1) clear_req(1);
    end
    m_accept_i = 1'b1;
    drain();

    // Protocol error: ack with nothing outstanding is sticky until reset.
    ack_en = 1'b1; step(); ack_en = 1'b0;
    step(); step();
    chk("proto_sticky", proto_err_o, 1'b1);
    new_req(0); step(); clear_req(0);
    new_req(1); step(); clear_req(1);
    rst = 1'b0; step(); rst = 1'b1;
    step();
    chk("rst_proto_clear", proto_err_o, 1'b0);
    chk("rst_busy_clear", busy_o, 1'b0);
    ack_en = 1'b1; step(); ack_en = 1'b0;
    step();
    chk("post_rst_stray_ack", proto_err_o, 1'b1);
    step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
